// File: rtl/layer_pkg.sv
// Shared types and sizing helpers for the fully-connected layer.
// Saturating output is selected with the LAYER_SATURATE_EN macro (see layer_neuron).
package layer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } neuron_state_t;

  // Product width plus enough guard bits to sum n_in products without overflow.
  function automatic int acc_width(input int in_w, input int wt_w, input int n_in);
    return in_w + wt_w + $clog2(n_in);
  endfunction

endpackage

// File: rtl/layer_neuron.sv
// One neuron: serial multiply-accumulate over its inputs, then shift/scale to output format.
// With LAYER_SATURATE_EN defined the scaled result saturates; otherwise it wraps.
module layer_neuron
  import layer_pkg::*;
#(
  parameter int NUM_INPUTS      = 5,
  parameter int INPUT_SIZE      = 9,
  parameter int WEIGHT_SIZE     = 17,
  parameter int OUTPUT_SIZE     = 10,
  parameter int INPUT_FRACTION  = 8,
  parameter int WEIGHT_FRACTION = 8,
  parameter int FRACTION_BITS   = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic                              i_active,
  input  logic [NUM_INPUTS*INPUT_SIZE-1:0]  i_inputs,
  input  logic [NUM_INPUTS*WEIGHT_SIZE-1:0] i_weights,
  output logic [OUTPUT_SIZE-1:0]            o_value,
  output logic                              o_valid,
  output logic                              o_busy
);

  localparam int ACC_W  = acc_width(INPUT_SIZE, WEIGHT_SIZE, NUM_INPUTS);
  localparam int PROD_W = INPUT_SIZE + WEIGHT_SIZE;
  localparam int IDX_W  = $clog2(NUM_INPUTS + 1);
  localparam int SHIFT  = INPUT_FRACTION + WEIGHT_FRACTION - FRACTION_BITS;

`ifdef LAYER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUTPUT_SIZE - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  neuron_state_t                  r_state;
  neuron_state_t                  w_state_nxt;
  logic [IDX_W-1:0]               r_idx;
  logic signed [ACC_W-1:0]        r_acc;
  logic [OUTPUT_SIZE-1:0]         r_value;
  logic                           r_valid;
  logic                           w_last;
  logic signed [INPUT_SIZE-1:0]   w_in;
  logic signed [WEIGHT_SIZE-1:0]  w_wt;
  logic signed [PROD_W-1:0]       w_prod;

  // Arithmetic shift floors toward minus infinity; then clamp or wrap to output width.
  function automatic logic [OUTPUT_SIZE-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef LAYER_SATURATE_EN
    logic signed [ACC_W-1:0] sh;
    sh = a >>> SHIFT;
    if (sh > SAT_MAX) begin
      sh = SAT_MAX;
    end else if (sh < SAT_MIN) begin
      sh = SAT_MIN;
    end
    return OUTPUT_SIZE'(sh);
`else
    return OUTPUT_SIZE'(a >>> SHIFT);
`endif
  endfunction

  always_comb begin
    w_in = '0;
    w_wt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_in = i_inputs[i*INPUT_SIZE +: INPUT_SIZE];
        w_wt = i_weights[i*WEIGHT_SIZE +: WEIGHT_SIZE];
      end
    end
  end

  assign w_prod = w_in * w_wt;

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start && i_active) begin
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        // One extra cycle after the last MAC registers the scaled result.
        if (r_idx == IDX_W'(NUM_INPUTS)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_idx   <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (i_start) begin
        r_valid <= 1'b0;
        if (i_active) begin
          r_acc <= '0;
          r_idx <= '0;
        end
      end
    end else if (w_last) begin
      r_value <= scale(r_acc);
      r_valid <= 1'b1;
    end else begin
      r_acc <= r_acc + ACC_W'(w_prod);
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_value = r_value;
  assign o_valid = r_valid;
  assign o_busy  = (r_state == ACC);

endmodule

// File: rtl/layer.sv
// Fully-connected layer: NUM_NEURON serial MAC neurons sharing one input vector.
// Output saturation is enabled by defining LAYER_SATURATE_EN.
module layer
  import layer_pkg::*;
#(
  parameter int NUM_NEURON      = 6,
  parameter int NUM_INPUTS      = 5,
  parameter int INPUT_SIZE      = 9,
  parameter int WEIGHT_SIZE     = 17,
  parameter int OUTPUT_SIZE     = 10,
  parameter int INPUT_FRACTION  = 8,
  parameter int WEIGHT_FRACTION = 8,
  parameter int FRACTION_BITS   = 7
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [NUM_NEURON-1:0]                        active,
  input  logic [NUM_INPUTS*INPUT_SIZE-1:0]             inputs,
  input  logic [NUM_NEURON*NUM_INPUTS*WEIGHT_SIZE-1:0] weights,
  output logic [NUM_NEURON*OUTPUT_SIZE-1:0]            out_values,
  output logic [NUM_NEURON-1:0]                        out_valid
);

  localparam int NW = NUM_INPUTS * WEIGHT_SIZE;

  logic [NUM_NEURON-1:0] w_busy;
  logic                  w_start;

  // A start arriving while any neuron is still accumulating is dropped entirely.
  assign w_start = start && (w_busy == '0);

  for (genvar n = 0; n < NUM_NEURON; n++) begin : g_neuron
    layer_neuron #(
      .NUM_INPUTS      (NUM_INPUTS),
      .INPUT_SIZE      (INPUT_SIZE),
      .WEIGHT_SIZE     (WEIGHT_SIZE),
      .OUTPUT_SIZE     (OUTPUT_SIZE),
      .INPUT_FRACTION  (INPUT_FRACTION),
      .WEIGHT_FRACTION (WEIGHT_FRACTION),
      .FRACTION_BITS   (FRACTION_BITS)
    ) u_neuron (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_active  (active[n]),
      .i_inputs  (inputs),
      .i_weights (weights[n*NW +: NW]),
      .o_value   (out_values[n*OUTPUT_SIZE +: OUTPUT_SIZE]),
      .o_valid   (out_valid[n]),
      .o_busy    (w_busy[n])
    );
  end

endmodule

// File: tb/tb_layer.sv
// Directed testbench for layer: hand-computed vectors for the default parameter set.
// Expected outputs follow LAYER_SATURATE_EN (saturating) or its absence (wrapping).
module tb_layer;

  localparam int NN = 6;
  localparam int NI = 5;
  localparam int IW = 9;
  localparam int WW = 17;
  localparam int OW = 10;

`ifdef LAYER_SATURATE_EN
  localparam logic [OW-1:0] EXP_N2  = 10'h200;
  localparam logic [OW-1:0] EXP_N34 = 10'h200;
  localparam logic [OW-1:0] EXP_N5  = 10'h200;
  localparam logic [OW-1:0] EXP_MAX = 10'h1FF;
`else
  localparam logic [OW-1:0] EXP_N2  = 10'h133;
  localparam logic [OW-1:0] EXP_N34 = 10'h000;
  localparam logic [OW-1:0] EXP_N5  = 10'h390;
  localparam logic [OW-1:0] EXP_MAX = 10'h17D;
`endif

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [NN-1:0]         active;
  logic [NI*IW-1:0]      inputs;
  logic [NN*NI*WW-1:0]   weights;
  logic [NN*OW-1:0]      out_values;
  logic [NN-1:0]         out_valid;

  int n_pass;
  int n_total;

  layer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .active     (active),
    .inputs     (inputs),
    .weights    (weights),
    .out_values (out_values),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] val(input int n);
    return out_values[n*OW +: OW];
  endfunction

  task automatic set_in(input int i, input int v);
    inputs[i*IW +: IW] = IW'(v);
  endtask

  task automatic set_w(input int n, input int i, input int v);
    weights[(n*NI+i)*WW +: WW] = WW'(v);
  endtask

  task automatic base_inputs();
    set_in(0, -40); set_in(1, 43); set_in(2, 103); set_in(3, 7); set_in(4, -150);
  endtask

  task automatic n0_weights();
    set_w(0, 0, 560); set_w(0, 1, -40); set_w(0, 2, -8); set_w(0, 3, 80); set_w(0, 4, -160);
  endtask

  // Leaves the bench 1 time unit after the edge that samples start.
  task automatic pulse_start(input logic [NN-1:0] act);
    @(posedge clk); #1;
    start  = 1'b1;
    active = act;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== '0) $display("FAIL reset_valid got=%b exp=0", out_valid);
    else n_pass++;
    n_total++;
    if (out_values !== '0) $display("FAIL reset_values got=%h exp=0", out_values);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_neuron();
    base_inputs();
    n0_weights();
    pulse_start(6'b000001);
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b000000) $display("FAIL single_early_valid got=%b exp=000000", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 6'b000001) $display("FAIL single_valid got=%b exp=000001", out_valid);
    else n_pass++;
    n_total++;
    if (val(0) !== 10'h3FF) $display("FAIL single_n0 got=%h exp=3ff", val(0));
    else n_pass++;
  endtask

  task automatic test_two_neurons();
    set_w(1, 0, 100); set_w(1, 1, 200); set_w(1, 2, 300); set_w(1, 3, 400); set_w(1, 4, 500);
    pulse_start(6'b000011);
    n_total++;
    if (out_valid !== 6'b000000) $display("FAIL two_clear_valid got=%b exp=000000", out_valid);
    else n_pass++;
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b000011) $display("FAIL two_valid got=%b exp=000011", out_valid);
    else n_pass++;
    n_total++;
    if (val(1) !== 10'h3B8) $display("FAIL two_n1 got=%h exp=3b8", val(1));
    else n_pass++;
    n_total++;
    if (val(0) !== 10'h3FF) $display("FAIL two_n0 got=%h exp=3ff", val(0));
    else n_pass++;
  endtask

  task automatic test_saturate_neg();
    for (int i = 0; i < NI; i++) begin
      set_w(2, i, 1000 * (i + 1));
      set_w(3, i, 10000 * (i + 1));
      set_w(4, i, 10000 * (i + 1));
    end
    set_w(5, 0, 50000); set_w(5, 1, 10000); set_w(5, 2, 20000); set_w(5, 3, 30000); set_w(5, 4, 40000);
    pulse_start(6'b111111);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b111111) $display("FAIL sat_valid got=%b exp=111111", out_valid);
    else n_pass++;
    n_total++;
    if (val(2) !== EXP_N2) $display("FAIL sat_n2 got=%h exp=%h", val(2), EXP_N2);
    else n_pass++;
    n_total++;
    if (val(3) !== EXP_N34 || val(4) !== EXP_N34)
      $display("FAIL sat_n34 got=%h,%h exp=%h", val(3), val(4), EXP_N34);
    else n_pass++;
    n_total++;
    if (val(5) !== EXP_N5) $display("FAIL sat_n5 got=%h exp=%h", val(5), EXP_N5);
    else n_pass++;
    n_total++;
    if (val(0) !== 10'h3FF || val(1) !== 10'h3B8)
      $display("FAIL sat_n01 got=%h,%h exp=3ff,3b8", val(0), val(1));
    else n_pass++;
  endtask

  task automatic test_inactive_hold();
    pulse_start(6'b000001);
    n_total++;
    if (out_valid !== 6'b000000) $display("FAIL hold_clear_valid got=%b exp=000000", out_valid);
    else n_pass++;
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b000001) $display("FAIL hold_valid got=%b exp=000001", out_valid);
    else n_pass++;
    n_total++;
    if (val(1) !== 10'h3B8 || val(5) !== EXP_N5)
      $display("FAIL hold_values got=%h,%h exp=3b8,%h", val(1), val(5), EXP_N5);
    else n_pass++;
  endtask

  task automatic test_max_positive();
    for (int i = 0; i < NI; i++) set_in(i, 255);
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++) set_w(n, i, 65535);
    pulse_start(6'b111111);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b111111) $display("FAIL max_valid got=%b exp=111111", out_valid);
    else n_pass++;
    for (int n = 0; n < NN; n++) begin
      n_total++;
      if (val(n) !== EXP_MAX) $display("FAIL max_n%0d got=%h exp=%h", n, val(n), EXP_MAX);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    base_inputs();
    n0_weights();
    pulse_start(6'b000001);
    @(posedge clk); #1;
    start  = 1'b1;
    active = 6'b111111;
    @(posedge clk); #1;
    start  = 1'b0;
    active = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b000000) $display("FAIL b2b_early_valid got=%b exp=000000", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 6'b000001) $display("FAIL b2b_valid got=%b exp=000001", out_valid);
    else n_pass++;
    n_total++;
    if (val(0) !== 10'h3FF) $display("FAIL b2b_n0 got=%h exp=3ff", val(0));
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b000001 || val(1) !== EXP_MAX)
      $display("FAIL b2b_after got=%b,%h exp=000001,%h", out_valid, val(1), EXP_MAX);
    else n_pass++;
  endtask

  task automatic test_all_inactive();
    pulse_start(6'b000000);
    n_total++;
    if (out_valid !== 6'b000000) $display("FAIL none_clear_valid got=%b exp=000000", out_valid);
    else n_pass++;
    repeat (8) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 6'b000000 || val(0) !== 10'h3FF)
      $display("FAIL none_after got=%b,%h exp=000000,3ff", out_valid, val(0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_start(6'b111111);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== '0 || out_values !== '0)
      $display("FAIL rstmid_now got=%b,%h exp=0,0", out_valid, out_values);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== '0 || out_values !== '0)
      $display("FAIL rstmid_after got=%b,%h exp=0,0", out_valid, out_values);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    start   = 1'b0;
    active  = '0;
    inputs  = '0;
    weights = '0;
    test_reset();
    test_single_neuron();
    test_two_neurons();
    test_saturate_neg();
    test_inactive_hold();
    test_max_positive();
    test_back_to_back();
    test_all_inactive();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
